scan_decoder: RTL and testbench

//  Parametrised, registered binary-to-one-hot decoder. Generalises the 3-to-8 decoder:
//  - 1 of 2**SEL_W outputs is driven high.
//  - Direct mode decodes an external select bus.
//  - Scan modes (up/down/ping-pong) step the active line from an internal index counter, with a programmable prescaler.
//  - Drives LED/segment/row strobes in the user-module I/O fabric.

---
 rtl/scan_decoder_pkg.sv | 23 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/scan_decoder.sv | 102 ++++++++++
 tb/tb_scan_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      DIRECT    = 2'b00,
      SCAN_UP   = 2'b01,
      SCAN_DOWN = 2'b10,
      PINGPONG  = 2'b11
   } mode_e;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_e;

   // Widest decode supported; callers truncate to their own N (SEL_W <= 8).
   localparam int ONEHOT_W = 256;

   function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
      onehot = ONEHOT_W'(1) << idx;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running terminal-count prescaler; tick marks the cycle where cnt == div.
module tick_prescaler #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // div is compared live; a lowered div lets cnt roll over naturally.
   assign tick = run && (cnt == div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (run)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with direct select and prescaled
// up/down/ping-pong scanning of an internal index.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DIV_W = 8,
   localparam int N    = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [SEL_W-1:0] sel,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic [N-1:0]     out,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

   localparam logic [SEL_W-1:0] IDX_MAX = '1;

   mode_e            m;
   dir_e             dir, dir_next;
   logic [SEL_W-1:0] idx_next;
   logic             wrap_next;
   logic             tick, pre_run, pre_clr;

   assign m       = mode_e'(mode);
   assign pre_run = en && (m != DIRECT);
   // Direct mode parks the prescaler; load restarts its phase.
   assign pre_clr = en && ((m == DIRECT) || load);

   tick_prescaler #(.DIV_W(DIV_W)) u_pre (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (pre_run),
      .clr   (pre_clr),
      .div   (div),
      .tick  (tick)
   );

   always_comb begin
      idx_next  = idx;
      dir_next  = dir;
      wrap_next = 1'b0;
      if (en) begin
         if (m == DIRECT) begin
            idx_next = sel;
         end else if (load) begin
            idx_next = sel;
            dir_next = UP;
         end else if (tick) begin
            unique case (m)
               SCAN_UP: begin
                  idx_next  = idx + 1'b1;
                  wrap_next = (idx == IDX_MAX);
               end
               SCAN_DOWN: begin
                  idx_next  = idx - 1'b1;
                  wrap_next = (idx == '0);
               end
               default: begin
                  if (dir == UP) begin
                     if (idx == IDX_MAX) begin
                        dir_next  = DOWN;
                        idx_next  = IDX_MAX - 1'b1;
                        wrap_next = 1'b1;
                     end else begin
                        idx_next = idx + 1'b1;
                     end
                  end else begin
                     if (idx == '0) begin
                        dir_next  = UP;
                        idx_next  = {{(SEL_W-1){1'b0}}, 1'b1};
                        wrap_next = 1'b1;
                     end else begin
                        idx_next = idx - 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         dir  <= UP;
         out  <= '0;
         wrap <= 1'b0;
      end else begin
         idx  <= idx_next;
         dir  <= dir_next;
         wrap <= wrap_next;
         out  <= en ? N'(onehot(int'(idx_next))) : '0;
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder (SEL_W=3, DIV_W=8).
module tb_scan_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [2:0] sel;
   logic       load;
   logic [7:0] div;
   logic [7:0] out;
   logic [2:0] idx;
   logic       wrap;

   int checks   = 0;
   int failures = 0;

   scan_decoder #(.SEL_W(3), .DIV_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .sel   (sel),
      .load  (load),
      .div   (div),
      .out   (out),
      .idx   (idx),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel = 3'd0; load = 1'b0; div = 8'd0;
      step(); step();
      checks++;
      if (out !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL reset: out=%h idx=%0d wrap=%b, want out=00 idx=0 wrap=0", out, idx, wrap);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_direct();
      en = 1'b1; mode = 2'b00; sel = 3'd5;
      step();
      checks++;
      if (out !== 8'b0010_0000 || idx !== 3'd5 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL direct_sel5: out=%b idx=%0d wrap=%b, want 00100000 5 0", out, idx, wrap);
      end
      sel = 3'd0;
      step();
      checks++;
      if (out !== 8'b0000_0001 || idx !== 3'd0) begin
         failures++;
         $display("FAIL direct_sel0: out=%b idx=%0d, want 00000001 0", out, idx);
      end
   endtask

   task automatic test_scan_up();
      logic [2:0] exp_idx [3] = '{3'd7, 3'd0, 3'd1};
      logic       exp_wrp [3] = '{1'b0, 1'b1, 1'b0};
      mode = 2'b01; div = 8'd0; sel = 3'd6; load = 1'b1;
      step();
      checks++;
      if (idx !== 3'd6 || wrap !== 1'b0 || out !== 8'h40) begin
         failures++;
         $display("FAIL up_load: idx=%0d wrap=%b out=%h, want 6 0 40", idx, wrap, out);
      end
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (idx !== exp_idx[i] || wrap !== exp_wrp[i]) begin
            failures++;
            $display("FAIL up_step%0d: idx=%0d wrap=%b, want %0d %b", i, idx, wrap, exp_idx[i], exp_wrp[i]);
         end
      end
   endtask

   task automatic test_scan_down_gap();
      // div=2: one step every 3 clocks starting right after load.
      logic [2:0] exp_idx [6] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd7};
      logic       exp_wrp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      mode = 2'b10; div = 8'd2; sel = 3'd1; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (idx !== exp_idx[i] || wrap !== exp_wrp[i]) begin
            failures++;
            $display("FAIL down_step%0d: idx=%0d wrap=%b, want %0d %b", i, idx, wrap, exp_idx[i], exp_wrp[i]);
         end
      end
      checks++;
      if (out !== 8'h80) begin
         failures++;
         $display("FAIL down_out7: out=%h, want 80", out);
      end
      step(); // cnt now 1, idx 7
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out !== 8'h00 || idx !== 3'd7 || wrap !== 1'b0 || dut.u_pre.cnt !== 8'd1) begin
            failures++;
            $display("FAIL down_gap%0d: out=%h idx=%0d wrap=%b cnt=%0d, want 00 7 0 1",
                     i, out, idx, wrap, dut.u_pre.cnt);
         end
      end
      en = 1'b1;
      step();
      checks++;
      if (idx !== 3'd7 || out !== 8'h80) begin
         failures++;
         $display("FAIL down_resume_hold: idx=%0d out=%h, want 7 80", idx, out);
      end
      step();
      checks++;
      if (idx !== 3'd6 || out !== 8'h40) begin
         failures++;
         $display("FAIL down_resume_step: idx=%0d out=%h, want 6 40", idx, out);
      end
   endtask

   task automatic test_pingpong();
      logic [2:0] exp_idx [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
      logic       exp_wrp [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [7:0] exp_out;
      mode = 2'b11; div = 8'd0; sel = 3'd6; load = 1'b1;
      step();
      load = 1'b0;
      checks++;
      if (idx !== 3'd6 || out !== 8'h40) begin
         failures++;
         $display("FAIL pp_load: idx=%0d out=%h, want 6 40", idx, out);
      end
      for (int i = 0; i < 9; i++) begin
         step();
         exp_out = 8'h01 << exp_idx[i];
         checks++;
         if (idx !== exp_idx[i] || wrap !== exp_wrp[i] || out !== exp_out || !$onehot(out)) begin
            failures++;
            $display("FAIL pp_step%0d: idx=%0d wrap=%b out=%b, want %0d %b %b",
                     i, idx, wrap, out, exp_idx[i], exp_wrp[i], exp_out);
         end
      end
   endtask

   task automatic test_load_vs_tick();
      // idx is 1 here and div=0, so a tick would otherwise give 2.
      mode = 2'b01; div = 8'd0; sel = 3'd3; load = 1'b1;
      step();
      load = 1'b0;
      checks++;
      if (idx !== 3'd3 || wrap !== 1'b0 || dut.u_pre.cnt !== 8'd0) begin
         failures++;
         $display("FAIL load_tick: idx=%0d wrap=%b cnt=%0d, want 3 0 0", idx, wrap, dut.u_pre.cnt);
      end
   endtask

   task automatic test_async_reset();
      // Drive ping-pong past the top so dir is down before reset.
      mode = 2'b11; div = 8'd0;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (idx !== 3'd6) begin
         failures++;
         $display("FAIL prereset_idx: idx=%0d, want 6", idx);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: out=%h idx=%0d wrap=%b, want 00 0 0", out, idx, wrap);
      end
      #1 rst_n = 1'b1;
      step();
      checks++;
      if (idx !== 3'd1 || wrap !== 1'b0 || out !== 8'h02) begin
         failures++;
         $display("FAIL post_reset1: idx=%0d wrap=%b out=%h, want 1 0 02", idx, wrap, out);
      end
      step();
      checks++;
      if (idx !== 3'd2 || wrap !== 1'b0 || out !== 8'h04) begin
         failures++;
         $display("FAIL post_reset2: idx=%0d wrap=%b out=%h, want 2 0 04", idx, wrap, out);
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan_up();
      test_scan_down_gap();
      test_pingpong();
      test_load_vs_tick();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
